dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the ARM core's data port: accepts MemWrite/MemRead with DataAdr/WriteData and returns ReadData plus a Ready handshake after a configurable number of wait states.
- Adds a completion mailbox. The first write to MAILBOX_ADDR raises Done and latches Pass when the written value equals PASS_VALUE. Benches and the FPGA top use these flags instead of snooping the bus.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; word index is DataAdr[31:2]
WAIT_CYCLES, 2, wait states inserted before Ready (0 allowed)
MAILBOX_ADDR, 100, byte address of the completion mailbox (word aligned)
PASS_VALUE, 7, mailbox value that signals success

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
MemRead  input  1  read request, sampled in IDLE
MemWrite  input  1  write request, sampled in IDLE
DataAdr  input  32  byte address
WriteData  input  32  write data
ByteEn  input  4  byte lane enables for writes; bit i controls bits 8i+7:8i
ReadData  output  32  read data, valid while Ready=1
Ready  output  1  one-cycle completion pulse
AddrErr  output  1  valid with Ready; request was misaligned or out of range
Done  output  1  sticky; mailbox has been written
Pass  output  1  sticky; first mailbox write carried PASS_VALUE
WriteCount  output  16  committed writes, saturating at 16'hFFFF

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - ReadData, Ready, AddrErr, Done, Pass and WriteCount all go to 0.
  - Memory array is NOT cleared.
  - An in-flight request is aborted: no commit, no Ready.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on an edge with MemRead|MemWrite=1, latch DataAdr, WriteData, ByteEn and op.
    - Go to WAIT with counter = WAIT_CYCLES-1.
    - If WAIT_CYCLES=0, go directly to RESP.
  - WAIT: decrement the counter each edge. At 0, go to RESP. Bus inputs are ignored.
  - RESP: Ready=1 for exactly one cycle, then IDLE. A request present in that cycle is not sampled until IDLE.
- Latency: request sampled at edge k gives Ready high in the cycle after edge k+WAIT_CYCLES+1. Back-to-back requests are spaced by WAIT_CYCLES+2 cycles.
- Commit: memory write, counter update and mailbox update happen on the edge entering RESP. ReadData is registered on that same edge from the pre-write word contents.
- MemRead and MemWrite both high is treated as a write; ReadData returns the old word.
- Error check: AddrErr=1 when latched DataAdr[1:0]!=0 or DataAdr[31:2]>=DEPTH_WORDS.
  - On error: no memory write, no count, no mailbox effect, ReadData=0.
  - Ready still pulses.
- The MAILBOX_ADDR word is also ordinary memory and is readable back.
- Mailbox: first non-error write to MAILBOX_ADDR with ByteEn=4'hF sets Done=1 and Pass=(WriteData==PASS_VALUE). Later mailbox writes update memory only; Done and Pass hold until Reset.
- WriteCount increments once per committed (non-error) write and holds at 16'hFFFF.
- Partial ByteEn: only enabled lanes change. ByteEn=0 still counts as a committed write.

Test Plan:
- Reset held 22 ns with MemWrite=1 mid-WAIT -> Ready never pulses, WriteCount=0, Done=0. After release, first request completes after 3 edges (WAIT_CYCLES=2).
- Write 32'hDEADBEEF to 0x20, then read 0x20 -> ReadData=32'hDEADBEEF with Ready; AddrErr=0; WriteCount=1; Ready pulses spaced ≥4 cycles.
- Write 96 then 100 with data 7 -> after the second Ready, Done=1 and Pass=1. A further write of 3 to 100 -> Done=1, Pass=1 unchanged; a read of 100 returns 3.
- Write 5 to 100 first -> Done=1, Pass=0 and sticky.
- Write to 0x22 and to byte 256 (DEPTH 64) -> AddrErr=1 with Ready, ReadData=0, WriteCount unchanged.
- ByteEn=4'b0010, WriteData=32'h0000AB00 over word 32'h11223344 -> read returns 32'h1122AB44.
- WAIT_CYCLES=0 build: a read issued at edge k gives Ready in the cycle after edge k+1.
- MemRead=MemWrite=1 -> returns the old word and the new data is committed.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-port bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [3:0]  ByteEn;
   logic [31:0] ReadData;
   logic        Ready;
   logic        AddrErr;
   logic        Done;
   logic        Pass;
   logic [15:0] WriteCount;

   modport master (
      output MemRead, MemWrite, DataAdr, WriteData, ByteEn,
      input  ReadData, Ready, AddrErr, Done, Pass, WriteCount
   );

   modport slave (
      input  MemRead, MemWrite, DataAdr, WriteData, ByteEn,
      output ReadData, Ready, AddrErr, Done, Pass, WriteCount
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word memory behind a wait-state FSM, plus a sticky
// completion mailbox (Done/Pass) and a saturating committed-write counter.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS  = 64,
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned MAILBOX_ADDR = 100,
   parameter logic [31:0] PASS_VALUE   = 32'd7
) (
   input logic             Clk,
   input logic             Reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned   AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned   CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD  = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 32'd1) : {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [29:0]   DEPTH_LIM = 30'(DEPTH_WORDS);
   localparam logic [31:0]   MBOX_ADR  = 32'(MAILBOX_ADDR);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        stateR;
   logic [CW-1:0] cntR;
   logic          isWriteR;
   logic [31:0]   adrR;
   logic [31:0]   dataR;
   logic [3:0]    beR;
   logic [31:0]   readDataR;
   logic          readyR;
   logic          addrErrR;
   logic          doneR;
   logic          passR;
   logic [15:0]   writeCountR;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          reqS;
   logic [31:0]   cAdrS;
   logic [31:0]   cDataS;
   logic [3:0]    cBeS;
   logic          cWriteS;
   logic          commitS;
   logic          errS;
   logic [AW-1:0] idxS;
   logic          memWeS;
   logic          mboxHitS;

   assign reqS = bus.MemRead | bus.MemWrite;

   // Select the request being committed; with no wait states it commits straight off the bus.
   always_comb begin
      cAdrS   = adrR;
      cDataS  = dataR;
      cBeS    = beR;
      cWriteS = isWriteR;
      commitS = 1'b0;
      if (WAIT_CYCLES == 0) begin
         cAdrS   = bus.DataAdr;
         cDataS  = bus.WriteData;
         cBeS    = bus.ByteEn;
         cWriteS = bus.MemWrite;
         commitS = (stateR == S_IDLE) && reqS;
      end else begin
         commitS = (stateR == S_WAIT) && (cntR == CNT_ZERO);
      end
   end

   // Address checks and commit qualifiers for the request being committed.
   always_comb begin
      errS     = (cAdrS[1:0] != 2'b00) || (cAdrS[31:2] >= DEPTH_LIM);
      idxS     = cAdrS[AW+1:2];
      memWeS   = commitS && cWriteS && !errS;
      mboxHitS = memWeS && (cAdrS == MBOX_ADR) && (cBeS == 4'hF) && !doneR;
   end

   // Request FSM: latch in IDLE, count wait states, then a single response cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateR   <= S_IDLE;
         cntR     <= CNT_ZERO;
         isWriteR <= 1'b0;
         adrR     <= 32'h0000_0000;
         dataR    <= 32'h0000_0000;
         beR      <= 4'h0;
         readyR   <= 1'b0;
      end else begin
         readyR <= (stateR == S_RESP);
         case (stateR)
            S_IDLE: begin
               if (reqS) begin
                  adrR     <= bus.DataAdr;
                  dataR    <= bus.WriteData;
                  beR      <= bus.ByteEn;
                  isWriteR <= bus.MemWrite;
                  cntR     <= CNT_LOAD;
                  stateR   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (cntR == CNT_ZERO) begin
                  stateR <= S_RESP;
               end else begin
                  cntR <= cntR - CW'(1'b1);
               end
            end
            S_RESP:  stateR <= S_IDLE;
            default: stateR <= S_IDLE;
         endcase
      end
   end

   // Response data, error flag, write counter and mailbox flags update on the commit edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         readDataR   <= 32'h0000_0000;
         addrErrR    <= 1'b0;
         doneR       <= 1'b0;
         passR       <= 1'b0;
         writeCountR <= 16'h0000;
      end else if (commitS) begin
         readDataR <= errS ? 32'h0000_0000 : mem[idxS];
         addrErrR  <= errS;
         if (memWeS && (writeCountR != 16'hFFFF)) begin
            writeCountR <= writeCountR + 16'd1;
         end
         if (mboxHitS) begin
            doneR <= 1'b1;
            passR <= (cDataS == PASS_VALUE);
         end
      end
   end

   // Storage array keeps its contents across Reset; only enabled byte lanes change.
   always_ff @(posedge Clk) begin
      if (memWeS) begin
         for (int i = 0; i < 4; i++) begin
            if (cBeS[i]) begin
               mem[idxS][8*i +: 8] <= cDataS[8*i +: 8];
            end
         end
      end
   end

   assign bus.ReadData   = readDataR;
   assign bus.Ready      = readyR;
   assign bus.AddrErr    = addrErrR;
   assign bus.Done       = doneR;
   assign bus.Pass       = passR;
   assign bus.WriteCount = writeCountR;
endmodule
